lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//  Memory stage directly downstream of the ALU: consumes the ALU result (effective address or
//  arithmetic result) plus rs2 store data and drives a req/gnt/rvalid data-memory port.
//  - Loads/stores: sequenced by an FSM; load data is extracted and sign/zero-extended.
//  - All other ops: registered straight through to writeback.
//  - Stalls the upstream pipeline while a memory access is outstanding.
// PARAMETERS
//  WD_SIZE      32  datapath/address width (from PARAMS_pkg)
//  REG_ADDR_SZ  5   destination register index width
// PORTS
//  clk            in   1            single clock, rising edge
//  reset_n        in   1            asynchronous, active-low reset
//  valid_i        in   1            EX result valid this cycle
//  opcode_i       in   OPCODE_SIZE  instruction opcode (OPCODE_LD / OPCODE_ST / other)
//  funct3_i       in   FUNCT3_SIZE  access size/sign (LB,LH,LW,LBU,LHU / SB,SH,SW)
//  alu_result_i   in   WD_SIZE      ALU output: address for LD/ST, result otherwise
//  rs2_data_i     in   WD_SIZE      store data
//  rd_i           in   REG_ADDR_SZ  destination register
//  wb_en_i        in   1            instruction writes rd
//  stall_o        out  1            upstream must hold its outputs
//  dmem_req_o     out  1            memory request
//  dmem_we_o      out  1            1 = store
//  dmem_addr_o    out  WD_SIZE      word-aligned address ({addr[31:2],2'b00})
//  dmem_be_o      out  4            byte enables
//  dmem_wdata_o   out  WD_SIZE      lane-replicated store data
//  dmem_gnt_i     in   1            request accepted
//  dmem_rvalid_i  in   1            load data valid
//  dmem_rdata_i   in   WD_SIZE      load data (full word)
//  valid_o        out  1            writeback entry valid
//  rd_o           out  REG_ADDR_SZ  writeback destination
//  wb_en_o        out  1            writeback enable
//  wb_data_o      out  WD_SIZE      writeback data
//  misalign_o     out  1            one-cycle pulse: misaligned LD/ST dropped
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; captured op registers cleared.
//  FSM IDLE -> REQ -> (WAIT_RSP) -> IDLE:
//   - IDLE, valid_i, non-mem op: next cycle valid_o=1, wb_data_o=alu_result_i, rd/wb_en passed.
//     Latency 1; back-to-back every cycle.
//   - IDLE, valid_i, mem op, aligned: capture addr/data/funct3/rd; ->REQ. valid_o=0 next cycle.
//   - Misaligned (H with addr[0]=1; W with addr[1:0]!=0): no request; next cycle
//     valid_o=1, wb_en_o=0, misalign_o=1; stay IDLE.
//   - REQ: dmem_req_o=1 and addr/we/be/wdata held stable until dmem_gnt_i.
//     On gnt: store -> IDLE, valid_o=1, wb_en_o=0 next cycle; load -> WAIT_RSP.
//   - WAIT_RSP: on dmem_rvalid_i -> IDLE; next cycle valid_o=1, wb_en_o=wb_en captured,
//     wb_data_o=formatted load.
//   - rvalid never arrives in the gnt cycle; it is ignored outside WAIT_RSP.
//  stall_o = (state!=IDLE) combinationally; inputs are sampled only in IDLE.
//  Minimum latencies: store = 2 cycles to valid_o with gnt in the REQ cycle; load = 3.
//  Load formatting (lane = addr[1:0]):
//   - LB/LBU: byte at lane, sign-/zero-extended.
//   - LH/LHU: half at addr[1], sign-/zero-extended.
//   - LW: full word.
//  Stores:
//   - SB: be=4'b0001<<lane, wdata={4{rs2[7:0]}}.
//   - SH: be=4'b0011<<(2*addr[1]), wdata={2{rs2[15:0]}}.
//   - SW: be=4'hF, wdata=rs2.
//  Undefined funct3 on LD/ST: treated as W.
//  valid_o, misalign_o: single-cycle pulses per instruction.
//  Reset mid-access (REQ/WAIT_RSP): abandon the access, return to IDLE, never report it.
// STRUCTURE
//  PARAMS_pkg additions:
//   - F3_LB/LH/LW/LBU/LHU, F3_SB/SH/SW.
//   - lsu_state_e {LSU_IDLE,LSU_REQ,LSU_WAIT}.
//   - REG_ADDR_SZ.
//  Sub-module load_align (comb): funct3 + addr[1:0] + rdata -> extended word.
//  FSM, capture registers and output registers live in lsu_mem_stage.
// TESTING
//  - ADD result 0x0000_0005 in IDLE -> next cycle valid_o=1, wb_data_o=5, stall_o=0.
//  - LB addr 0x103, rdata 0x80FF_FF12 (gnt after 2 cycles, rvalid +1) -> addr 0x100,
//    wb_data 0xFFFF_FF80; LBU gives 0x0000_0080.
//  - SH addr 0x202, rs2 0x1234_ABCD -> be=4'b1100, wdata 0xABCD_ABCD, valid_o wb_en_o=0.
//  - LW addr 0x301 -> no dmem_req_o, misalign_o=1, valid_o=1, wb_en_o=0.
//  - Load in WAIT_RSP, then reset_n=0 -> outputs 0 immediately; a late rvalid yields no valid_o.
//  - gnt held low 5 cycles -> req/addr/be stable, stall_o=1 throughout.

Source files
------------

// File: rtl/lsu_mem_stage_pkg.sv
// Shared types, constants and access-size helpers for the LSU memory stage.
// Covers opcode/funct3 encodings, the LSU state enum and byte-lane helpers.
package lsu_mem_stage_pkg;

    localparam int WD_SIZE     = 32;
    localparam int REG_ADDR_SZ = 5;
    localparam int OPCODE_SIZE = 7;
    localparam int FUNCT3_SIZE = 3;

    localparam logic [OPCODE_SIZE-1:0] OPCODE_LD = 7'b0000011;
    localparam logic [OPCODE_SIZE-1:0] OPCODE_ST = 7'b0100011;

    localparam logic [FUNCT3_SIZE-1:0] F3_LB  = 3'd0;
    localparam logic [FUNCT3_SIZE-1:0] F3_LH  = 3'd1;
    localparam logic [FUNCT3_SIZE-1:0] F3_LW  = 3'd2;
    localparam logic [FUNCT3_SIZE-1:0] F3_LBU = 3'd4;
    localparam logic [FUNCT3_SIZE-1:0] F3_LHU = 3'd5;
    localparam logic [FUNCT3_SIZE-1:0] F3_SB  = 3'd0;
    localparam logic [FUNCT3_SIZE-1:0] F3_SH  = 3'd1;
    localparam logic [FUNCT3_SIZE-1:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT
    } lsu_state_e;

    typedef enum logic [1:0] {
        ACC_BYTE,
        ACC_HALF,
        ACC_WORD
    } acc_size_e;

    // Any funct3 that is not a defined byte/half encoding behaves as a word access.
    function automatic acc_size_e f_acc_size(input logic i_is_load,
                                             input logic [FUNCT3_SIZE-1:0] i_funct3);
        acc_size_e size;
        size = ACC_WORD;
        if (i_is_load) begin
            case (i_funct3)
                F3_LB, F3_LBU: size = ACC_BYTE;
                F3_LH, F3_LHU: size = ACC_HALF;
                F3_LW:         size = ACC_WORD;
                default:       size = ACC_WORD;
            endcase
        end else begin
            case (i_funct3)
                F3_SB:   size = ACC_BYTE;
                F3_SH:   size = ACC_HALF;
                F3_SW:   size = ACC_WORD;
                default: size = ACC_WORD;
            endcase
        end
        return size;
    endfunction

    function automatic logic f_misaligned(input acc_size_e i_size, input logic [1:0] i_lane);
        logic mis;
        case (i_size)
            ACC_HALF: mis = i_lane[0];
            ACC_WORD: mis = (i_lane != 2'b00);
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] f_byte_en(input acc_size_e i_size, input logic [1:0] i_lane);
        logic [3:0] be;
        case (i_size)
            ACC_BYTE: be = 4'b0001 << i_lane;
            ACC_HALF: be = 4'b0011 << {i_lane[1], 1'b0};
            default:  be = 4'hF;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// Combinational load formatter: picks the addressed byte/half out of the
// returned word and sign- or zero-extends it according to funct3.
module load_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [FUNCT3_SIZE-1:0] i_funct3,
    input  logic [1:0]             i_lane,
    input  logic [WD_SIZE-1:0]     i_rdata,
    output logic [WD_SIZE-1:0]     o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_lane)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Undefined encodings fall through to a plain word load.
    always_comb begin
        case (i_funct3)
            F3_LB:   o_data = {{(WD_SIZE-8){w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {{(WD_SIZE-8){1'b0}}, w_byte};
            F3_LH:   o_data = {{(WD_SIZE-16){w_half[15]}}, w_half};
            F3_LHU:  o_data = {{(WD_SIZE-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage behind the ALU: sequences loads/stores over a req/gnt/rvalid
// data port, passes other results through, and stalls upstream while busy.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   valid_i,
    input  logic [OPCODE_SIZE-1:0] opcode_i,
    input  logic [FUNCT3_SIZE-1:0] funct3_i,
    input  logic [WD_SIZE-1:0]     alu_result_i,
    input  logic [WD_SIZE-1:0]     rs2_data_i,
    input  logic [REG_ADDR_SZ-1:0] rd_i,
    input  logic                   wb_en_i,
    output logic                   stall_o,
    output logic                   dmem_req_o,
    output logic                   dmem_we_o,
    output logic [WD_SIZE-1:0]     dmem_addr_o,
    output logic [3:0]             dmem_be_o,
    output logic [WD_SIZE-1:0]     dmem_wdata_o,
    input  logic                   dmem_gnt_i,
    input  logic                   dmem_rvalid_i,
    input  logic [WD_SIZE-1:0]     dmem_rdata_i,
    output logic                   valid_o,
    output logic [REG_ADDR_SZ-1:0] rd_o,
    output logic                   wb_en_o,
    output logic [WD_SIZE-1:0]     wb_data_o,
    output logic                   misalign_o
);

    lsu_state_e r_state, w_next_state;

    logic [WD_SIZE-1:0]     r_addr;
    logic [WD_SIZE-1:0]     r_store_data;
    logic [FUNCT3_SIZE-1:0] r_funct3;
    logic [REG_ADDR_SZ-1:0] r_rd;
    logic                   r_wb_en;
    logic                   r_is_load;

    logic                   r_valid;
    logic                   r_misalign;
    logic                   r_wb_en_out;
    logic [REG_ADDR_SZ-1:0] r_rd_out;
    logic [WD_SIZE-1:0]     r_wb_data;

    logic                   w_capture;
    logic                   w_valid_nxt;
    logic                   w_misalign_nxt;
    logic                   w_wb_en_nxt;
    logic [REG_ADDR_SZ-1:0] w_rd_nxt;
    logic [WD_SIZE-1:0]     w_wb_data_nxt;

    logic                   w_is_load;
    logic                   w_is_store;
    acc_size_e              w_in_size;
    logic                   w_in_misaligned;
    acc_size_e              w_cap_size;
    logic                   w_in_req;
    logic [WD_SIZE-1:0]     w_store_wdata;
    logic [WD_SIZE-1:0]     w_load_data;

    assign w_is_load       = (opcode_i == OPCODE_LD);
    assign w_is_store      = (opcode_i == OPCODE_ST);
    assign w_in_size       = f_acc_size(w_is_load, funct3_i);
    assign w_in_misaligned = f_misaligned(w_in_size, alu_result_i[1:0]);
    assign w_cap_size      = f_acc_size(r_is_load, r_funct3);
    assign w_in_req        = (r_state == LSU_REQ);

    load_align u_load_align (
        .i_funct3 (r_funct3),
        .i_lane   (r_addr[1:0]),
        .i_rdata  (dmem_rdata_i),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_capture      = 1'b0;
        w_valid_nxt    = 1'b0;
        w_misalign_nxt = 1'b0;
        w_wb_en_nxt    = 1'b0;
        w_rd_nxt       = r_rd_out;
        w_wb_data_nxt  = r_wb_data;
        case (r_state)
            LSU_IDLE: begin
                if (valid_i) begin
                    if (w_is_load || w_is_store) begin
                        if (w_in_misaligned) begin
                            w_valid_nxt    = 1'b1;
                            w_misalign_nxt = 1'b1;
                            w_rd_nxt       = rd_i;
                            w_wb_data_nxt  = '0;
                        end else begin
                            w_capture    = 1'b1;
                            w_next_state = LSU_REQ;
                        end
                    end else begin
                        w_valid_nxt   = 1'b1;
                        w_wb_en_nxt   = wb_en_i;
                        w_rd_nxt      = rd_i;
                        w_wb_data_nxt = alu_result_i;
                    end
                end
            end
            LSU_REQ: begin
                if (dmem_gnt_i) begin
                    if (r_is_load) begin
                        w_next_state = LSU_WAIT;
                    end else begin
                        w_next_state  = LSU_IDLE;
                        w_valid_nxt   = 1'b1;
                        w_rd_nxt      = r_rd;
                        w_wb_data_nxt = '0;
                    end
                end
            end
            LSU_WAIT: begin
                if (dmem_rvalid_i) begin
                    w_next_state  = LSU_IDLE;
                    w_valid_nxt   = 1'b1;
                    w_wb_en_nxt   = r_wb_en;
                    w_rd_nxt      = r_rd;
                    w_wb_data_nxt = w_load_data;
                end
            end
            default: w_next_state = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr       <= '0;
            r_store_data <= '0;
            r_funct3     <= '0;
            r_rd         <= '0;
            r_wb_en      <= 1'b0;
            r_is_load    <= 1'b0;
        end else if (w_capture) begin
            r_addr       <= alu_result_i;
            r_store_data <= rs2_data_i;
            r_funct3     <= funct3_i;
            r_rd         <= rd_i;
            r_wb_en      <= wb_en_i;
            r_is_load    <= w_is_load;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid     <= 1'b0;
            r_misalign  <= 1'b0;
            r_wb_en_out <= 1'b0;
            r_rd_out    <= '0;
            r_wb_data   <= '0;
        end else begin
            r_valid     <= w_valid_nxt;
            r_misalign  <= w_misalign_nxt;
            r_wb_en_out <= w_wb_en_nxt;
            r_rd_out    <= w_rd_nxt;
            r_wb_data   <= w_wb_data_nxt;
        end
    end

    // Store data is replicated across every lane of its size so the byte enables alone select it.
    always_comb begin
        case (w_cap_size)
            ACC_BYTE: w_store_wdata = {4{r_store_data[7:0]}};
            ACC_HALF: w_store_wdata = {2{r_store_data[15:0]}};
            default:  w_store_wdata = r_store_data;
        endcase
    end

    assign stall_o      = (r_state != LSU_IDLE);
    assign dmem_req_o   = w_in_req;
    assign dmem_we_o    = w_in_req & ~r_is_load;
    assign dmem_addr_o  = w_in_req ? {r_addr[WD_SIZE-1:2], 2'b00} : '0;
    assign dmem_be_o    = w_in_req ? f_byte_en(w_cap_size, r_addr[1:0]) : 4'b0000;
    assign dmem_wdata_o = (w_in_req && !r_is_load) ? w_store_wdata : '0;

    assign valid_o    = r_valid;
    assign misalign_o = r_misalign;
    assign wb_en_o    = r_wb_en_out;
    assign rd_o       = r_rd_out;
    assign wb_data_o  = r_wb_data;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: directed corner cases then random traffic,
// with expectations produced by a byte-arithmetic model of loads and stores.
module tb_lsu_mem_stage;

    localparam logic [6:0] OP_LD  = 7'h03;
    localparam logic [6:0] OP_ST  = 7'h23;
    localparam logic [6:0] OP_ADD = 7'h33;

    logic        clk           = 1'b0;
    logic        reset_n       = 1'b0;
    logic        valid_i       = 1'b0;
    logic [6:0]  opcode_i      = '0;
    logic [2:0]  funct3_i      = '0;
    logic [31:0] alu_result_i  = '0;
    logic [31:0] rs2_data_i    = '0;
    logic [4:0]  rd_i          = '0;
    logic        wb_en_i       = 1'b0;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i    = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i  = '0;
    logic        valid_o;
    logic [4:0]  rd_o;
    logic        wb_en_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;

    always #5 clk = ~clk;

    lsu_mem_stage dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .valid_i       (valid_i),
        .opcode_i      (opcode_i),
        .funct3_i      (funct3_i),
        .alu_result_i  (alu_result_i),
        .rs2_data_i    (rs2_data_i),
        .rd_i          (rd_i),
        .wb_en_i       (wb_en_i),
        .stall_o       (stall_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .valid_o       (valid_o),
        .rd_o          (rd_o),
        .wb_en_o       (wb_en_o),
        .wb_data_o     (wb_data_o),
        .misalign_o    (misalign_o)
    );

    typedef struct {
        bit          wbEn;
        bit          misalign;
        logic [4:0]  rd;
        logic [31:0] data;
    } wbExp_t;

    typedef struct {
        logic [31:0] addr;
        bit          isStore;
        logic [3:0]  be;
        logic [31:0] wdata;
    } reqExp_t;

    wbExp_t      wbQ[$];
    reqExp_t     reqQ[$];
    logic [31:0] rdataQ[$];

    int checks = 0;
    int errors = 0;
    int gntCfg = -1;
    int rvCfg  = -1;
    bit spuriousOn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: sizes, lanes and extension computed with plain arithmetic.
    task automatic modelIssue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                              input logic [31:0] rs2, input logic [31:0] rdata,
                              input logic [4:0] rd, input bit wbEn);
        wbExp_t      w;
        reqExp_t     r;
        int          sizeB;
        int          lane;
        int          beI;
        logic [31:0] mask;
        logic [31:0] v;
        lane   = int'(alu % 4);
        w.wbEn = 1'b0; w.misalign = 1'b0; w.rd = rd; w.data = '0;
        if (op != OP_LD && op != OP_ST) begin
            w.wbEn = wbEn; w.data = alu;
            wbQ.push_back(w);
            return;
        end
        if (op == OP_LD) sizeB = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        else             sizeB = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
        if (lane % sizeB != 0) begin
            w.misalign = 1'b1;
            wbQ.push_back(w);
            return;
        end
        beI       = ((1 << sizeB) - 1) << lane;
        r.addr    = alu & 32'hFFFF_FFFC;
        r.isStore = (op == OP_ST);
        r.be      = beI[3:0];
        if (sizeB == 1)      r.wdata = {24'b0, rs2[7:0]} * 32'h0101_0101;
        else if (sizeB == 2) r.wdata = {16'b0, rs2[15:0]} * 32'h0001_0001;
        else                 r.wdata = rs2;
        reqQ.push_back(r);
        if (op == OP_ST) begin
            wbQ.push_back(w);
            return;
        end
        mask = (sizeB == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sizeB)) - 32'h1);
        v    = (rdata >> (8 * lane)) & mask;
        if (f3 < 4 && sizeB < 4 && v[8 * sizeB - 1]) v = v | ~mask;
        w.wbEn = wbEn; w.data = v;
        wbQ.push_back(w);
        rdataQ.push_back(rdata);
    endtask

    // Presents one instruction and holds it until an edge where the stage is not stalled.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                                 input logic [31:0] rs2, input logic [31:0] rdata,
                                 input logic [4:0] rd, input bit wbEn);
        bit busy;
        int waited = 0;
        opcode_i = op; funct3_i = f3; alu_result_i = alu; rs2_data_i = rs2;
        rd_i = rd; wb_en_i = wbEn; valid_i = 1'b1;
        do begin
            busy = stall_o;
            @(posedge clk); #1;
            waited++;
        end while (busy && waited < 200);
        valid_i = 1'b0;
        if (busy) begin
            checks++; errors++;
            $display("[TB] FAIL issue_timeout: stall_o still 1 after %0d cycles, required 0", waited);
            return;
        end
        modelIssue(op, f3, alu, rs2, rdata, rd, wbEn);
    endtask

    task automatic drain();
        int waited = 0;
        while ((wbQ.size() != 0 || reqQ.size() != 0 || stall_o) && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (wbQ.size() != 0 || reqQ.size() != 0 || stall_o) begin
            checks++; errors++;
            $display("[TB] FAIL drain_timeout: %0d wb and %0d req pending, required 0", wbQ.size(), reqQ.size());
        end
    endtask

    // Memory model: grant after a configured or random delay, return load data afterwards.
    task automatic memRespond();
        bit isLoad;
        int gd;
        int rvd;
        isLoad = !dmem_we_o;
        gd  = (gntCfg >= 0) ? gntCfg : int'($urandom_range(0, 3));
        rvd = (rvCfg >= 0) ? rvCfg : int'($urandom_range(0, 2));
        repeat (gd) begin
            if (spuriousOn) begin
                dmem_rvalid_i = ($urandom_range(0, 2) == 0);
                dmem_rdata_i  = $urandom;
            end
            @(posedge clk); #1;
        end
        dmem_rvalid_i = 1'b0;
        dmem_gnt_i    = 1'b1;
        @(posedge clk); #1;
        dmem_gnt_i    = 1'b0;
        if (isLoad) begin
            repeat (rvd) begin
                @(posedge clk); #1;
            end
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = (rdataQ.size() != 0) ? rdataQ.pop_front() : $urandom;
            @(posedge clk); #1;
            dmem_rvalid_i = 1'b0;
        end
    endtask

    initial begin : memResponder
        forever begin
            @(posedge clk); #1;
            if (reset_n && dmem_req_o) memRespond();
        end
    end

    // Writeback monitor: every valid_o pulse must match the oldest expected result.
    always @(negedge clk) begin : wbMonitor
        wbExp_t e;
        if (valid_o) begin
            if (wbQ.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL unexpected_valid: got valid_o=1 rd=%0d, required no writeback", rd_o);
            end else begin
                e = wbQ.pop_front();
                checkOutput("wb_en", 32'(wb_en_o), 32'(e.wbEn));
                checkOutput("misalign", 32'(misalign_o), 32'(e.misalign));
                if (e.wbEn) begin
                    checkOutput("rd", 32'(rd_o), 32'(e.rd));
                    checkOutput("wb_data", wb_data_o, e.data);
                end
            end
        end else if (misalign_o) begin
            checks++; errors++;
            $display("[TB] FAIL stray_misalign: got misalign_o=1 with valid_o=0, required 0");
        end
    end

    // Request monitor: request fields must equal the expected access on every cycle until granted.
    always @(negedge clk) begin : reqMonitor
        reqExp_t r;
        if (dmem_req_o) begin
            if (reqQ.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL unexpected_req: got dmem_req_o=1 addr=0x%08h, required none", dmem_addr_o);
            end else begin
                r = reqQ[0];
                checkOutput("req_stall", 32'(stall_o), 32'd1);
                checkOutput("req_addr", dmem_addr_o, r.addr);
                checkOutput("req_we", 32'(dmem_we_o), 32'(r.isStore));
                if (r.isStore) begin
                    checkOutput("req_be", 32'(dmem_be_o), 32'(r.be));
                    checkOutput("req_wdata", dmem_wdata_o, r.wdata);
                end
                if (dmem_gnt_i) void'(reqQ.pop_front());
            end
        end
    end

    initial begin : mainSeq
        logic [6:0] ops [5];
        logic [6:0] op;
        int         kind;
        ops[0] = OP_ADD; ops[1] = 7'h13; ops[2] = 7'h37; ops[3] = 7'h17; ops[4] = 7'h6F;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_req", 32'(dmem_req_o), 32'd0);
        checkOutput("rst_we", 32'(dmem_we_o), 32'd0);
        checkOutput("rst_addr", dmem_addr_o, 32'd0);
        checkOutput("rst_be", 32'(dmem_be_o), 32'd0);
        checkOutput("rst_wdata", dmem_wdata_o, 32'd0);
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_wb_en", 32'(wb_en_o), 32'd0);
        checkOutput("rst_rd", 32'(rd_o), 32'd0);
        checkOutput("rst_wb_data", wb_data_o, 32'd0);
        checkOutput("rst_misalign", 32'(misalign_o), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(OP_ADD, 3'd0, 32'h0000_0005, 32'h0, 32'h0, 5'd3, 1'b1);
        checkOutput("add_valid", 32'(valid_o), 32'd1);
        checkOutput("add_stall", 32'(stall_o), 32'd0);
        drain();

        gntCfg = 2; rvCfg = 0;
        applyStimulus(OP_LD, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_FF12, 5'd7, 1'b1);
        drain();
        applyStimulus(OP_LD, 3'd4, 32'h0000_0103, 32'h0, 32'h80FF_FF12, 5'd8, 1'b1);
        drain();

        gntCfg = 0;
        applyStimulus(OP_ST, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 5'd4, 1'b1);
        drain();

        applyStimulus(OP_LD, 3'd2, 32'h0000_0301, 32'h0, 32'h0, 5'd5, 1'b1);
        @(negedge clk);
        checkOutput("mis_no_req", 32'(dmem_req_o), 32'd0);
        @(posedge clk); #1;
        drain();

        gntCfg = 5;
        applyStimulus(OP_ST, 3'd2, 32'h0000_0500, 32'hCAFE_F00D, 32'h0, 5'd6, 1'b0);
        drain();

        gntCfg = 0; rvCfg = 3;
        applyStimulus(OP_LD, 3'd2, 32'h0000_0400, 32'h0, 32'h1357_9BDF, 5'd9, 1'b1);
        @(posedge clk); #1;
        checkOutput("wait_stall", 32'(stall_o), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_stall", 32'(stall_o), 32'd0);
        checkOutput("midrst_req", 32'(dmem_req_o), 32'd0);
        checkOutput("midrst_valid", 32'(valid_o), 32'd0);
        wbQ.delete();
        reqQ.delete();
        @(posedge clk); #3;
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkOutput("late_rvalid_valid", 32'(valid_o), 32'd0);
        end
        @(posedge clk); #1;
        rdataQ.delete();

        gntCfg = -1; rvCfg = -1; spuriousOn = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            kind = int'($urandom_range(0, 9));
            if (kind < 4)      op = ops[$urandom_range(0, 4)];
            else if (kind < 7) op = OP_LD;
            else               op = OP_ST;
            applyStimulus(op, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
